// File: rtl/router_vc_input_buffer.sv
// Per-VC circular flit FIFOs with one registered output port and a drop pulse for refused sends.
// Optional same-cycle bypass into an empty VC when ROUTER_IBUF_BYPASS_EN is defined.
module router_vc_input_buffer #(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned VC_COUNT   = 2,
  parameter  int unsigned VC_DEPTH   = 4,
  localparam int unsigned VC_W       = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1,
  localparam int unsigned CNT_W      = $clog2(VC_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send,
  input  logic [VC_W-1:0]       in_vc,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  input  logic [VC_W-1:0]       out_vc,
  input  logic                  blocked,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [VC_COUNT-1:0]   vc_empty,
  output logic                  drop
);

  localparam int unsigned PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;

  logic [PTR_W-1:0]      head_q  [VC_COUNT];
  logic [PTR_W-1:0]      tail_q  [VC_COUNT];
  logic [CNT_W-1:0]      count_q [VC_COUNT];
  logic [DATA_WIDTH-1:0] mem_q   [VC_COUNT][VC_DEPTH];

  logic                in_ok_c;
  logic                out_ok_c;
  logic [VC_W-1:0]     in_idx_c;
  logic [VC_W-1:0]     out_idx_c;
  logic                push_c;
  logic                pop_c;
  logic                bypass_c;
  logic                store_c;
  logic [VC_COUNT-1:0] push_vc_c;
  logic [VC_COUNT-1:0] pop_vc_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push/pop qualification; out-of-range VC indices never touch a FIFO.
  always_comb begin
    in_ok_c   = (32'(in_vc) < VC_COUNT);
    out_ok_c  = (32'(out_vc) < VC_COUNT);
    in_idx_c  = in_ok_c ? in_vc : '0;
    out_idx_c = out_ok_c ? out_vc : '0;
    ready     = in_ok_c && (count_q[in_idx_c] != CNT_W'(VC_DEPTH));
    push_c    = send && ready;
    pop_c     = !blocked && out_ok_c && (count_q[out_idx_c] != '0);
`ifdef ROUTER_IBUF_BYPASS_EN
    bypass_c  = push_c && (in_vc == out_vc) && (count_q[in_idx_c] == '0) && !blocked;
`else
    bypass_c  = 1'b0;
`endif
    store_c   = push_c && !bypass_c;
    push_vc_c = '0;
    pop_vc_c  = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      push_vc_c[v] = store_c && (in_idx_c == VC_W'(v));
      pop_vc_c[v]  = pop_c && (out_idx_c == VC_W'(v));
    end
  end

  always_comb begin
    vc_empty = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      vc_empty[v] = (count_q[v] == '0);
    end
  end

  // Pointers, counts and the registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        head_q[v]  <= '0;
        tail_q[v]  <= '0;
        count_q[v] <= '0;
      end
      data_out  <= '0;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      for (int v = 0; v < VC_COUNT; v++) begin
        if (push_vc_c[v]) tail_q[v] <= ptr_inc(tail_q[v]);
        if (pop_vc_c[v])  head_q[v] <= ptr_inc(head_q[v]);
        if (push_vc_c[v] && !pop_vc_c[v]) begin
          count_q[v] <= count_q[v] + CNT_W'(1);
        end else if (pop_vc_c[v] && !push_vc_c[v]) begin
          count_q[v] <= count_q[v] - CNT_W'(1);
        end
      end
      drop      <= send && !ready;
      out_valid <= pop_c || bypass_c;
      if (pop_c) begin
        data_out <= mem_q[out_idx_c][head_q[out_idx_c]];
      end else if (bypass_c) begin
        data_out <= data_in;
      end else begin
        data_out <= '0;
      end
    end
  end

  // Flit storage is deliberately not reset; counts alone define validity.
  always_ff @(posedge clk) begin
    if (store_c) begin
      mem_q[in_idx_c][tail_q[in_idx_c]] <= data_in;
    end
  end

endmodule
